// File: rtl/fpu_resq_pkg.sv
// Shared types and encodings for the FPU result queue: entry layout, read selects,
// status word bit positions and the FPU unit numbering carried in each entry.
package fpu_resq_pkg;

    localparam int UNITS   = 11;
    localparam int DATA_W  = 32;
    localparam int FLAGS_W = 5;
    localparam int OP_W    = 2;
    localparam int UNIT_W  = 4;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [FLAGS_W-1:0] flags;
        logic [OP_W-1:0]    op;
        logic [UNIT_W-1:0]  unit;
    } entry_t;

    typedef enum logic [1:0] {
        SEL_DATA   = 2'd0,
        SEL_TAG    = 2'd1,
        SEL_STATUS = 2'd2,
        SEL_STICKY = 2'd3
    } rd_sel_e;

    localparam int ST_COUNT_LSB = 0;
    localparam int ST_EMPTY_BIT = 8;
    localparam int ST_FULL_BIT  = 9;
    localparam int ST_OVF_BIT   = 10;
    localparam int ST_UDF_BIT   = 11;
    localparam int ST_DROP_LSB  = 16;

    // Bit index of res_valid that names each unit.
    typedef enum logic [3:0] {
        UNIT_FCLASS  = 4'd0,
        UNIT_FMV     = 4'd1,
        UNIT_FCVT_FI = 4'd2,
        UNIT_FCVT_IF = 4'd3,
        UNIT_FCMP    = 4'd4,
        UNIT_FMINMAX = 4'd5,
        UNIT_FSGNJ   = 4'd6,
        UNIT_FMA     = 4'd7,
        UNIT_FMUL    = 4'd8,
        UNIT_FDIV    = 4'd9,
        UNIT_FSQRT   = 4'd10
    } unit_e;

    // Highest set valid bit wins when several units report together.
    function automatic logic [UNIT_W-1:0] unit_of(input logic [UNITS-1:0] vld);
        logic [UNIT_W-1:0] u;
        u = '0;
        for (int i = 0; i < UNITS; i++) begin
            if (vld[i]) u = UNIT_W'(i);
        end
        return u;
    endfunction

    function automatic logic [31:0] tag_word(input entry_t e);
        return {19'b0, e.unit, e.op, e.flags, 2'b0};
    endfunction

endpackage

// File: rtl/fpu_result_queue_if.sv
// Result-push and register-read bus of the FPU result queue; the queue is the slave.
interface fpu_result_queue_if;
    logic [10:0] res_valid;
    logic [31:0] res_data;
    logic [4:0]  res_flags;
    logic [1:0]  res_op;
    logic        rd_en;
    logic [1:0]  rd_sel;
    logic        flags_clr;
    logic [31:0] rd_data;
    logic        rd_ack;
    logic        irq;
    logic        empty;
    logic        full;

    modport slave (
        input  res_valid, res_data, res_flags, res_op, rd_en, rd_sel, flags_clr,
        output rd_data, rd_ack, irq, empty, full
    );

    modport master (
        output res_valid, res_data, res_flags, res_op, rd_en, rd_sel, flags_clr,
        input  rd_data, rd_ack, irq, empty, full
    );
endinterface

// File: rtl/fpu_resq_ram.sv
// Entry storage with write/read pointers and fill count; the caller guarantees
// push never happens on a full queue without a simultaneous pop.
module fpu_resq_ram
    import fpu_resq_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  entry_t        wr_entry,
    output entry_t        head_entry,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_entry;
    end

    assign head_entry = mem[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/fpu_result_queue.sv
// FPU result queue: captures FPU results, exposes head/tag/status/sticky registers.
// Optional macro FPU_RESQ_THRESH_IRQ_EN switches irq to fill-threshold/overflow mode.
module fpu_result_queue
    import fpu_resq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int THRESH = 4
) (
    input logic                 clk,
    input logic                 rst,
    fpu_result_queue_if.slave   bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    // An out-of-range THRESH leaves irq permanently low rather than misfiring.
    localparam bit THRESH_OK = (THRESH >= 1) && (THRESH <= DEPTH);

    entry_t        wr_entry, head_entry;
    logic [CW-1:0] count_w;
    logic          empty_w, full_w;
    logic          push_req, pop, accept, drop, rd_data_sel;
    logic [31:0]   status_w;

    logic [4:0]  sticky_q, sticky_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_ack_q, rd_ack_d;
    logic        irq_q, irq_d;

    fpu_resq_ram #(.DEPTH(DEPTH)) u_ram (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .pop        (pop),
        .wr_entry   (wr_entry),
        .head_entry (head_entry),
        .count      (count_w)
    );

    assign empty_w = (count_w == '0);
    assign full_w  = (count_w == CW'(DEPTH));

    always_comb begin
        wr_entry.data  = bus.res_data;
        wr_entry.flags = bus.res_flags;
        wr_entry.op    = bus.res_op;
        wr_entry.unit  = unit_of(bus.res_valid);

        push_req    = |bus.res_valid;
        rd_data_sel = bus.rd_en && (bus.rd_sel == SEL_DATA);
        pop         = rd_data_sel && !empty_w;
        // A pop in the same cycle frees the slot a full queue needs.
        accept      = push_req && (!full_w || pop);
        drop        = push_req && full_w && !pop;

        status_w = '0;
        status_w[ST_COUNT_LSB +: 8] = 8'(count_w);
        status_w[ST_EMPTY_BIT]      = empty_w;
        status_w[ST_FULL_BIT]       = full_w;
        status_w[ST_OVF_BIT]        = overflow_q;
        status_w[ST_UDF_BIT]        = underflow_q;
        status_w[ST_DROP_LSB +: 8]  = drop_cnt_q;

        // Clear happens first so events of the clearing cycle still register.
        sticky_d    = bus.flags_clr ? 5'b0 : sticky_q;
        overflow_d  = (overflow_q && !bus.flags_clr) || drop;
        underflow_d = (underflow_q && !bus.flags_clr) || (rd_data_sel && empty_w);
        drop_cnt_d  = bus.flags_clr ? 8'd0 : drop_cnt_q;
        if (accept) sticky_d = sticky_d | bus.res_flags;
        if (drop && (drop_cnt_d != 8'hFF)) drop_cnt_d = drop_cnt_d + 8'd1;

        rd_ack_d  = bus.rd_en;
        rd_data_d = '0;
        if (bus.rd_en) begin
            case (bus.rd_sel)
                SEL_DATA:   rd_data_d = empty_w ? 32'd0 : head_entry.data;
                SEL_TAG:    rd_data_d = empty_w ? 32'd0 : tag_word(head_entry);
                SEL_STATUS: rd_data_d = status_w;
                default:    rd_data_d = {27'b0, sticky_q};
            endcase
        end

`ifdef FPU_RESQ_THRESH_IRQ_EN
        irq_d = THRESH_OK && ((count_w >= CW'(THRESH)) || overflow_q);
`else
        irq_d = THRESH_OK && !empty_w;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            drop_cnt_q  <= '0;
            rd_data_q   <= '0;
            rd_ack_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            sticky_q    <= sticky_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            drop_cnt_q  <= drop_cnt_d;
            rd_data_q   <= rd_data_d;
            rd_ack_q    <= rd_ack_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_ack  = rd_ack_q;
    assign bus.irq     = irq_q;
    assign bus.empty   = empty_w;
    assign bus.full    = full_w;

endmodule

// File: tb/tb_fpu_result_queue.sv
// Directed scenarios plus a random phase, every cycle checked against a queue-based model.
module tb_fpu_result_queue;

    localparam int DEPTH  = 8;
    localparam int THRESH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_result_queue_if bus();

    fpu_result_queue #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: entries packed as {data[42:11], flags[10:6], op[5:4], unit[3:0]}.
    logic [42:0] mq[$];
    logic [4:0]  m_sticky;
    bit          m_ovf, m_udf, m_rd_ack, m_irq;
    int          m_drop;
    logic [31:0] m_rd_data;

    function automatic logic [3:0] top_unit(input logic [10:0] v);
        for (int i = 10; i >= 0; i--) if (v[i]) return 4'(i);
        return 4'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_sticky = '0; m_ovf = 0; m_udf = 0; m_drop = 0;
        m_rd_data = '0; m_rd_ack = 0; m_irq = 0;
    endtask

    // Applies one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        int cnt;
        bit pop, push;
        logic [42:0] e;
        cnt  = mq.size();
        pop  = bus.rd_en && bus.rd_sel == 2'd0 && cnt > 0;
        push = |bus.res_valid;
        m_rd_ack  = bus.rd_en;
        m_rd_data = '0;
        if (bus.rd_en) begin
            case (bus.rd_sel)
                2'd0: if (cnt > 0) m_rd_data = mq[0][42:11];
                2'd1: if (cnt > 0) m_rd_data = {19'b0, mq[0][3:0], mq[0][5:4], mq[0][10:6], 2'b0};
                2'd2: m_rd_data = {8'b0, 8'(m_drop), 4'b0, m_udf, m_ovf,
                                   cnt == DEPTH, cnt == 0, 8'(cnt)};
                default: m_rd_data = {27'b0, m_sticky};
            endcase
        end
`ifdef FPU_RESQ_THRESH_IRQ_EN
        m_irq = (cnt >= THRESH) || m_ovf;
`else
        m_irq = (cnt != 0);
`endif
        if (bus.flags_clr) begin
            m_sticky = '0; m_ovf = 0; m_udf = 0; m_drop = 0;
        end
        if (bus.rd_en && bus.rd_sel == 2'd0 && cnt == 0) m_udf = 1;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (cnt < DEPTH || pop) begin
                e = {bus.res_data, bus.res_flags, bus.res_op, top_unit(bus.res_valid)};
                mq.push_back(e);
                m_sticky = m_sticky | bus.res_flags;
            end else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
    endtask

    task automatic compare_all();
        chk("rd_ack", {31'b0, bus.rd_ack}, {31'b0, m_rd_ack});
        chk("rd_data", bus.rd_data, m_rd_data);
        chk("empty", {31'b0, bus.empty}, {31'b0, mq.size() == 0});
        chk("full", {31'b0, bus.full}, {31'b0, mq.size() == DEPTH});
        chk("irq", {31'b0, bus.irq}, {31'b0, m_irq});
    endtask

    task automatic clear_inputs();
        bus.res_valid = '0; bus.res_data = '0; bus.res_flags = '0; bus.res_op = '0;
        bus.rd_en = 1'b0; bus.rd_sel = '0; bus.flags_clr = 1'b0;
    endtask

    task automatic do_cyc(input logic [10:0] vld, input logic [31:0] d, input logic [4:0] f,
                          input logic [1:0] op, input logic re, input logic [1:0] sel,
                          input logic clr);
        bus.res_valid = vld; bus.res_data = d; bus.res_flags = f; bus.res_op = op;
        bus.rd_en = re; bus.rd_sel = sel; bus.flags_clr = clr;
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        $display("cyc vld=%h d=%h f=%b re=%b sel=%0d clr=%b -> ack=%b rd=%h cnt=%0d irq=%b",
                 vld, d, f, re, sel, clr, bus.rd_ack, bus.rd_data, mq.size(), bus.irq);
        clear_inputs();
    endtask

    task automatic push(input logic [10:0] vld, input logic [31:0] d, input logic [4:0] f);
        do_cyc(vld, d, f, 2'd1, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] sel);
        do_cyc('0, '0, '0, '0, 1'b1, sel, 1'b0);
    endtask

    task automatic idle();
        do_cyc('0, '0, '0, '0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic clr_and_drain();
        do_cyc('0, '0, '0, '0, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < DEPTH + 1 && mq.size() > 0; i++) rd(2'd0);
        idle();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset_empty", {31'b0, bus.empty}, 32'd1);
        chk("reset_full", {31'b0, bus.full}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Single push then pop of one result.
        push(11'h040, 32'h40490FDB, 5'b00001);
        rd(2'd1);
        chk("t34_tag", bus.rd_data, {19'b0, 4'd6, 2'd1, 5'b00001, 2'b0});
        rd(2'd0);
        chk("t34_data", bus.rd_data, 32'h40490FDB);
        chk("t34_empty", {31'b0, bus.empty}, 32'd1);

        // Underflow on empty data read.
        do_cyc('0, '0, '0, '0, 1'b0, 2'd0, 1'b1);
        rd(2'd0);
        chk("t36_data", bus.rd_data, 32'd0);
        rd(2'd2);
        chk("t36_status", bus.rd_data, 32'h0000_0900);

        // Nine pushes into eight slots.
        do_cyc('0, '0, '0, '0, 1'b0, 2'd0, 1'b1);
        for (int i = 1; i <= 9; i++) push(11'h001 << (i % 11), 32'(i), 5'd0);
        chk("t35_full", {31'b0, bus.full}, 32'd1);
        rd(2'd2);
        chk("t35_status", bus.rd_data, 32'h0001_0608);
        for (int i = 1; i <= 8; i++) begin
            rd(2'd0);
            chk("t35_order", bus.rd_data, 32'(i));
        end

        // Push and pop together on a full queue.
        clr_and_drain();
        for (int i = 0; i < DEPTH; i++) push(11'h100, 32'hA000_0000 + 32'(i), 5'd0);
        do_cyc(11'h200, 32'hBEEF_0001, 5'd0, 2'd2, 1'b1, 2'd0, 1'b0);
        chk("t37_pop", bus.rd_data, 32'hA000_0000);
        rd(2'd2);
        chk("t37_status", bus.rd_data, 32'h0000_0208);
        for (int i = 1; i < DEPTH; i++) rd(2'd0);
        rd(2'd0);
        chk("t37_last", bus.rd_data, 32'hBEEF_0001);

        // Sticky flags accumulate; clear with a coincident push keeps that push's flags.
        clr_and_drain();
        push(11'h004, 32'h1, 5'b10000);
        push(11'h004, 32'h2, 5'b00100);
        rd(2'd3);
        chk("t38_sticky", bus.rd_data, 32'h0000_0014);
        do_cyc(11'h004, 32'h3, 5'b00001, 2'd0, 1'b0, 2'd0, 1'b1);
        rd(2'd3);
        chk("t38_clr", bus.rd_data, 32'h0000_0001);

        // Interrupt behaviour.
        clr_and_drain();
        chk("t39_irq_idle", {31'b0, bus.irq}, 32'd0);
`ifdef FPU_RESQ_THRESH_IRQ_EN
        for (int i = 0; i < THRESH - 1; i++) push(11'h010, 32'(i), 5'd0);
        idle();
        chk("t39_irq_below", {31'b0, bus.irq}, 32'd0);
        push(11'h010, 32'h99, 5'd0);
        idle();
        chk("t39_irq_thresh", {31'b0, bus.irq}, 32'd1);
`else
        push(11'h010, 32'h99, 5'd0);
        idle();
        chk("t39_irq_first", {31'b0, bus.irq}, 32'd1);
`endif

        // Random traffic.
        clr_and_drain();
        for (int n = 0; n < 400; n++) begin
            do_cyc(($urandom_range(0, 1) != 0) ? 11'($urandom) : 11'd0, $urandom, 5'($urandom),
                   2'($urandom), ($urandom_range(0, 1) != 0), 2'($urandom),
                   ($urandom_range(0, 19) == 0));
        end

        // Reset in the middle of traffic, with a read in flight.
        for (int i = 0; i < 3; i++) push(11'h002, 32'h55 + 32'(i), 5'b00010);
        bus.rd_en = 1'b1; bus.rd_sel = 2'd0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_mid_empty", {31'b0, bus.empty}, 32'd1);
        chk("rst_mid_ack", {31'b0, bus.rd_ack}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid_ack_edge", {31'b0, bus.rd_ack}, 32'd0);
        clear_inputs();
        rst = 1'b0;
        idle();
        rd(2'd2);
        chk("rst_mid_status", bus.rd_data, 32'h0000_0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_result_queue.md
FPU_RESULT_QUEUE -- requirements
Module: fpu_result_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of result entries (power of two, 2..64).
REQ-002 SHALL have parameter THRESH, default 4, fill level that raises irq when FPU_RESQ_THRESH_IRQ_EN is defined (1..DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port res_valid  input  11  per-unit result valid from the FPU (sqrt..f-class, bit 10..0).
REQ-006 SHALL have port res_data  input  32  FPU result word.
REQ-007 SHALL have port res_flags  input  5  FPU exception flags (NV,DZ,OF,UF,NX).
REQ-008 SHALL have port res_op  input  2  op sub-code accompanying the result.
REQ-009 SHALL have port rd_en  input  1  register read strobe from the bus side.
REQ-010 SHALL have port rd_sel  input  2  read select: 0 head data (pops), 1 head tag, 2 status, 3 sticky flags.
REQ-011 SHALL have port flags_clr  input  1  clears sticky flags, overflow, underflow, drop count.
REQ-012 SHALL have port rd_data  output  32  registered read data.
REQ-013 SHALL have port rd_ack  output  1  registered read acknowledge.
REQ-014 SHALL have port irq  output  1  registered interrupt request.
REQ-015 SHALL have ports empty, full  output  1 each  combinational from count.

Function
REQ-016 SHALL push one entry {data, flags, op, unit} on any cycle where |res_valid is 1; unit = index of highest set bit (4 bits).
REQ-017 SHALL, when full and not popping that cycle, drop the push, set overflow sticky, and increment the 8-bit drop counter, saturating at 255.
REQ-018 SHALL accept a push while full if a pop occurs in the same cycle; count unchanged.
REQ-019 SHALL pop the head on rd_en with rd_sel=0 when not empty; rd_data = head data on the next cycle.
REQ-020 SHALL, on rd_en with rd_sel=0 when empty, return 0, not pop, and set underflow sticky.
REQ-021 SHALL assert rd_ack exactly one cycle after every rd_en, for one cycle; rd_data is valid only with rd_ack and holds 0 otherwise.
REQ-022 SHALL return tag word {19'b0, unit[12:9], op[8:7], flags[6:2], 2'b0} for rd_sel=1 without popping; 0 when empty.
REQ-023 SHALL return status word {8'b0, drop_cnt[23:16], 4'b0, underflow[11], overflow[10], full[9], empty[8], count[7:0]} for rd_sel=2.
REQ-024 SHALL return {27'b0, sticky[4:0]} for rd_sel=3; sticky ORs in res_flags of every accepted push.
REQ-025 SHALL, when flags_clr and an accepted push coincide, leave sticky equal to that push's flags.
REQ-026 SHALL make a pushed entry readable on the cycle after the push edge; pointers wrap modulo DEPTH.
REQ-027 SHALL sample rd_data for status/sticky reads from pre-edge state (same-cycle push not visible).

Reset
REQ-028 SHALL on rst clear pointers, count, sticky, overflow, underflow, drop counter, rd_data, rd_ack and irq to 0 immediately; empty=1, full=0.
REQ-029 SHALL discard all entries on reset mid-operation; no read acknowledged for an rd_en concurrent with rst.

Configuration
REQ-030 SHALL, with FPU_RESQ_THRESH_IRQ_EN defined, drive irq high the cycle after count >= THRESH or overflow sticky is set.
REQ-031 SHALL, without FPU_RESQ_THRESH_IRQ_EN, drive irq high the cycle after count becomes nonzero; THRESH unused.

Structure
REQ-032 SHALL place the entry struct typedef, rd_sel encodings, status bit positions and unit encodings in package fpu_resq_pkg.
REQ-033 SHALL implement storage and pointers in one sub-module fpu_resq_ram (DEPTH x 43-bit, 1 write/1 read port).

Verification
REQ-034 Push res_valid=11'h040, data=32'h40490FDB, flags=5'b00001; read sel=0 -> rd_ack next cycle, rd_data=32'h40490FDB, empty=1 after.
REQ-035 Push 9 results with DEPTH=8 -> full=1, status overflow=1, drop_cnt=1; 8 pops return results 1..8 in order.
REQ-036 Read sel=0 when empty -> rd_data=0, underflow=1, count stays 0.
REQ-037 Full queue, push and pop same cycle -> count stays 8, overflow stays 0, new entry read last.
REQ-038 Push flags 5'b10000 then 5'b00100 -> sticky=5'b10100; flags_clr with push of 5'b00001 -> sticky=5'b00001.
REQ-039 With macro defined, THRESH=4: 3 pushes irq=0, 4th push irq=1 next cycle; without macro irq=1 after first push.
